memory_responder: RTL and testbench

// - Target side of the CPU memory request channel. Accepts one read or write at a time from the
//   CPU control/datapath and returns exactly one response per request.
// - Routes each request to the synchronous program/data RAM, or to a small memory-mapped I/O

---
 rtl/memory_responder_if.sv | 18 +
 rtl/memory_responder.sv | 82 ++++++++
 tb/tb_memory_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// memory_responder_if: CPU memory request/response channel between the CPU (master) and the responder (slave).
interface memory_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_address;
    logic [15:0] req_write_data;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_read_data;
    modport master (
        output req_valid, req_write, req_address, req_write_data,
        input  req_ready, resp_valid, resp_read_data
    );
    modport slave (
        input  req_valid, req_write, req_address, req_write_data,
        output req_ready, resp_valid, resp_read_data
    );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: one-at-a-time memory target routing requests to a synchronous RAM or a small MMIO page.
// Define MEM_RESPONDER_CYCLE_COUNTER_EN to add a free-running cycle counter at MMIO_BASE+2.
module memory_responder #(
    parameter int          RAM_LATENCY = 1,
    parameter logic [15:0] MMIO_BASE   = 16'hFFF0
) (
    input  logic                     clock,
    input  logic                     reset,
    memory_responder_if.slave        bus,
    output logic [15:0]              ram_address,
    output logic                     ram_write_enable,
    output logic [15:0]              ram_write_data,
    input  logic [15:0]              ram_read_data,
    input  logic [15:0]              switches,
    output logic [15:0]              leds
);
    localparam logic [2:0]  LATENCY  = 3'(RAM_LATENCY);
    localparam logic [15:0] LEDS_ADDR = MMIO_BASE;
    localparam logic [15:0] SW_ADDR   = MMIO_BASE + 16'd1;
    localparam logic [15:0] CNT_ADDR  = MMIO_BASE + 16'd2;
    typedef enum logic [1:0] {IDLE, RWAIT, WDONE, RESP} state_t;
    state_t      state, state_next;
    logic [2:0]  count;
    logic [15:0] switches_meta, switches_sync, cycle_value, mmio_data;
    logic        accept, is_mmio;
    assign accept  = bus.req_valid && bus.req_ready;
    assign is_mmio = bus.req_address >= MMIO_BASE;
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
    logic [15:0] cycles;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cycles <= '0;
        else cycles <= (accept && bus.req_write && bus.req_address == CNT_ADDR) ? 16'd0 : cycles + 16'd1;
    end
    assign cycle_value = cycles;
`else
    assign cycle_value = '0;
`endif
    assign mmio_data = bus.req_address == LEDS_ADDR ? leds :
                       bus.req_address == SW_ADDR   ? switches_sync :
                       bus.req_address == CNT_ADDR  ? cycle_value : 16'd0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state == IDLE  ? (accept ? (is_mmio ? RESP : bus.req_write ? WDONE : RWAIT) : IDLE) :
                     state == RWAIT ? (count == 3'd0 ? RESP : RWAIT) :
                     state == WDONE ? RESP : IDLE;
    end
    always_comb begin
        bus.req_ready  = state == IDLE;
        bus.resp_valid = state == RESP;
    end
    // Every resp_read_data update happens on the edge entering RESP, so it holds between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count              <= '0;
            ram_address        <= '0;
            ram_write_enable   <= 1'b0;
            ram_write_data     <= '0;
            leds               <= '0;
            switches_meta      <= '0;
            switches_sync      <= '0;
            bus.resp_read_data <= '0;
        end else begin
            switches_meta    <= switches;
            switches_sync    <= switches_meta;
            ram_write_enable <= accept && !is_mmio && bus.req_write;
            if (accept && !is_mmio) begin
                ram_address <= bus.req_address;
                count       <= LATENCY;
            end else if (state == RWAIT && count != 3'd0) begin
                count <= count - 3'd1;
            end
            if (accept && !is_mmio && bus.req_write) ram_write_data <= bus.req_write_data;
            if (accept && is_mmio && bus.req_write && bus.req_address == LEDS_ADDR) leds <= bus.req_write_data;
            if (accept && is_mmio) bus.resp_read_data <= bus.req_write ? 16'd0 : mmio_data;
            else if (state == RWAIT && count == 3'd0) bus.resp_read_data <= ram_read_data;
            else if (state == WDONE) bus.resp_read_data <= 16'd0;
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench for memory_responder with a RAM_LATENCY=1 RAM model.
module tb_memory_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ram_address, ram_write_data, ram_read_data, switches, leds;
    logic        ram_write_enable;
    logic [15:0] mem [0:65535];
    memory_responder_if bus ();
    memory_responder #(.RAM_LATENCY(1), .MMIO_BASE(16'hFFF0)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .ram_address(ram_address), .ram_write_enable(ram_write_enable),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .switches(switches), .leds(leds)
    );
    typedef struct {logic [15:0] data; int lat; bit chk; int acc;} exp_t;
    exp_t        sb [$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, resp_cyc = -10, resp_cnt = 0, acc_cnt = 0;
    int          we_cnt = 0, last_acc = 0;
    logic [15:0] we_addr = '0, we_data = '0, last_data = '0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clock) begin
        if (ram_write_enable) begin
            we_cnt++;
            we_addr = ram_address;
            we_data = ram_write_data;
        end
        if (bus.resp_valid) begin
            exp_t e;
            resp_cnt++;
            resp_cyc = cyc;
            check("resp_ready_low", 32'(bus.req_ready), 0);
            check("resp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                last_data = bus.resp_read_data;
                check("resp_latency", cyc - e.acc, e.lat);
                if (e.chk) check("resp_data", 32'(bus.resp_read_data), 32'(e.data));
            end
        end
    end
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp, input int lat, input bit chk);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_address = a;
        bus.req_write_data = d;
        while (!bus.req_ready && n < 50) begin @(negedge clock); n++; end
        check("accept_wait", 32'(n < 50), 1);
        last_acc = cyc;
        acc_cnt++;
        sb.push_back('{exp, lat, chk, last_acc});
        @(negedge clock);
        bus.req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clock); n++; end
        check("resp_wait", 32'(n < 50), 1);
        sb.delete();
        while (cyc <= resp_cyc) @(negedge clock);
        check("ready_after_resp", 32'(bus.req_ready), 1);
    endtask
    initial begin
        int we0;
        logic [15:0] v1, v2;
        int a1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_address = '0; bus.req_write_data = '0;
        switches = 16'h0000;
        mem[16'h0040] = 16'hBEEF;
        repeat (2) @(negedge clock);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_data", 32'(bus.resp_read_data), 0);
        check("rst_ram_addr", 32'(ram_address), 0);
        check("rst_ram_we", 32'(ram_write_enable), 0);
        check("rst_leds", 32'(leds), 0);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_rst", 32'(bus.req_ready), 1);
        do_req(0, 16'h0040, 16'h0, 16'hBEEF, 3, 1);
        we0 = we_cnt;
        do_req(1, 16'h0041, 16'h1234, 16'h0000, 2, 1);
        check("we_pulses", we_cnt - we0, 1);
        check("we_addr", 32'(we_addr), 32'h0041);
        check("we_data", 32'(we_data), 32'h1234);
        do_req(0, 16'h0041, 16'h0, 16'h1234, 3, 1);
        we0 = we_cnt;
        do_req(1, 16'hFFF0, 16'h00A5, 16'h0000, 1, 1);
        check("leds_written", 32'(leds), 32'h00A5);
        check("mmio_no_we", we_cnt - we0, 0);
        do_req(0, 16'hFFF0, 16'h0, 16'h00A5, 1, 1);
        switches = 16'h0F0F;
        repeat (3) @(negedge clock);
        do_req(0, 16'hFFF1, 16'h0, 16'h0F0F, 1, 1);
        do_req(1, 16'hFFF5, 16'h9999, 16'h0000, 1, 1);
        do_req(0, 16'hFFF5, 16'h0, 16'h0000, 1, 1);
        do_req(0, 16'hFFFF, 16'h0, 16'h0000, 1, 1);
        check("leds_kept", 32'(leds), 32'h00A5);
        we0 = we_cnt;
        do_req(1, 16'hFFEF, 16'h7777, 16'h0000, 2, 1);
        check("below_base_we", we_cnt - we0, 1);
        check("below_base_addr", 32'(we_addr), 32'hFFEF);
        do_req(0, 16'hFFEF, 16'h0, 16'h7777, 3, 1);
        // Keep req_valid up with changing contents while busy; only the first request may be serviced.
        we0 = we_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0040;
        check("hold_ready", 32'(bus.req_ready), 1);
        acc_cnt++;
        sb.push_back('{16'hBEEF, 3, 1'b1, cyc});
        @(negedge clock);
        bus.req_write = 1'b1; bus.req_address = 16'hFFF0; bus.req_write_data = 16'hFFFF;
        @(negedge clock);
        bus.req_address = 16'h0041;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("hold_leds", 32'(leds), 32'h00A5);
        check("hold_no_we", we_cnt - we0, 0);
        check("hold_sb_empty", 32'(sb.size()), 0);
        sb.delete();
        do_req(0, 16'h0041, 16'h0, 16'h1234, 3, 1);
        // Reset while the read is in RWAIT abandons it.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0040;
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(bus.resp_valid), 0);
        check("midrst_ram_addr", 32'(ram_address), 0);
        check("midrst_resp_data", 32'(bus.resp_read_data), 0);
        check("midrst_leds", 32'(leds), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_midrst", 32'(bus.req_ready), 1);
        do_req(0, 16'h0040, 16'h0, 16'hBEEF, 3, 1);
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
        do_req(0, 16'hFFF2, 16'h0, 16'h0, 1, 0);
        v1 = last_data;
        a1 = last_acc;
        while (cyc < a1 + 10) @(negedge clock);
        do_req(0, 16'hFFF2, 16'h0, 16'h0, 1, 0);
        v2 = last_data;
        check("cnt_diff", 32'(16'(v2 - v1)), 10);
        do_req(1, 16'hFFF2, 16'h1234, 16'h0000, 1, 1);
        do_req(0, 16'hFFF2, 16'h0, 16'h0, 1, 0);
        check("cnt_cleared", 32'(last_data < 16'd16), 1);
`else
        do_req(0, 16'hFFF2, 16'h0, 16'h0000, 1, 1);
        do_req(1, 16'hFFF2, 16'h5555, 16'h0000, 1, 1);
        do_req(0, 16'hFFF2, 16'h0, 16'h0000, 1, 1);
`endif
        repeat (3) @(negedge clock);
        check("resp_count", resp_cnt, acc_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
